// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// cpu_run_ctrl: host sequencer that loads program/data images, runs the cpu until HALT_MAGIC or budget, then reads back dmem.
// Revision 1.0
module cpu_run_ctrl #(
  parameter int unsigned IMEM_WORDS   = 512,
  parameter int unsigned DMEM_WORDS   = 1024,
  parameter logic [63:0] MAILBOX_ADDR = 64'h1FF8,
  parameter logic [63:0] HALT_MAGIC   = 64'h00000000DEADBEEF
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic        load_target,
  input  logic        load_last,
  input  logic [63:0] load_data,
  input  logic        go,
  input  logic [31:0] cycle_limit,
  input  logic        clear,
  input  logic        rd_req,
  input  logic [63:0] rd_addr,
  output logic        rd_valid,
  output logic [63:0] rd_data,
  output logic        cpu_enable,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  input  logic [31:0] rdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        load_err,
  output logic [31:0] cycles_run
);

  localparam int IPW = $clog2(IMEM_WORDS + 1);
  localparam int DPW = $clog2(DMEM_WORDS + 1);
  localparam logic [IPW-1:0] C_IMEM_FULL = IPW'(IMEM_WORDS);
  localparam logic [DPW-1:0] C_DMEM_FULL = DPW'(DMEM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CLR  = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t         state, state_nx;
  logic [IPW-1:0] imem_ptr, imem_ptr_nx;
  logic [DPW-1:0] dmem_ptr, dmem_ptr_nx;
  logic           poll_pending, poll_nx;
  logic           rd_issue, rd_issue_nx;
  logic           rd_ret, rd_ret_nx;
  logic           beat, halt;

  logic        load_ready_nx, rd_valid_nx, cpu_enable_nx, busy_nx, done_nx;
  logic        timeout_nx, load_err_nx, wen_ext_nx, wen_ext_2_nx, ren_ext_2_nx;
  logic [63:0] rd_data_nx, addr_ext_nx, addr_ext_2_nx, wdata_ext_2_nx;
  logic [31:0] wdata_ext_nx, cycles_nx;

  // The imem ext read port is reserved; it is never strobed or consumed.
  logic unused_rdata;
  assign unused_rdata = ^rdata_ext;

  always_comb begin
    state_nx       = state;
    imem_ptr_nx    = imem_ptr;
    dmem_ptr_nx    = dmem_ptr;
    load_err_nx    = load_err;
    timeout_nx     = timeout;
    cycles_nx      = cycles_run;
    rd_data_nx     = rd_data;
    wen_ext_nx     = 1'b0;
    addr_ext_nx    = '0;
    wdata_ext_nx   = '0;
    wen_ext_2_nx   = 1'b0;
    ren_ext_2_nx   = 1'b0;
    addr_ext_2_nx  = '0;
    wdata_ext_2_nx = '0;
    rd_issue_nx    = 1'b0;
    rd_ret_nx      = rd_issue;
    rd_valid_nx    = rd_ret;
    poll_nx        = (state == S_RUN);
    beat           = load_valid && load_ready;
    halt           = poll_pending && (rdata_ext_2 == HALT_MAGIC);

    if (rd_ret) rd_data_nx = rdata_ext_2;

    case (state)
      S_IDLE, S_LOAD: begin
        if (beat) begin
          state_nx = load_last ? S_IDLE : S_LOAD;
          if (!load_target) begin
            if (imem_ptr == C_IMEM_FULL) begin
              load_err_nx = 1'b1;
            end else begin
              wen_ext_nx   = 1'b1;
              addr_ext_nx  = 64'(imem_ptr) << 2;
              wdata_ext_nx = load_data[31:0];
              imem_ptr_nx  = imem_ptr + IPW'(1);
            end
          end else begin
            if (dmem_ptr == C_DMEM_FULL) begin
              load_err_nx = 1'b1;
            end else begin
              wen_ext_2_nx   = 1'b1;
              addr_ext_2_nx  = 64'(dmem_ptr) << 3;
              wdata_ext_2_nx = load_data;
              dmem_ptr_nx    = dmem_ptr + DPW'(1);
            end
          end
        end else if (go && (state == S_IDLE)) begin
          state_nx = S_CLR;
        end
        if (clear) begin
          imem_ptr_nx = '0;
          dmem_ptr_nx = '0;
          load_err_nx = 1'b0;
        end
      end
      S_CLR: state_nx = S_RUN;
      S_RUN: begin
        // Halt is checked first so a simultaneous budget expiry does not flag timeout.
        if (halt) begin
          state_nx = S_DONE;
        end else if ((cycle_limit != 32'd0) && (cycles_run == cycle_limit - 32'd1)) begin
          state_nx   = S_DONE;
          timeout_nx = 1'b1;
        end
      end
      S_DONE: begin
        if (rd_req) begin
          ren_ext_2_nx  = 1'b1;
          addr_ext_2_nx = rd_addr;
          rd_issue_nx   = 1'b1;
        end
        if (clear) begin
          state_nx    = S_IDLE;
          imem_ptr_nx = '0;
          dmem_ptr_nx = '0;
          load_err_nx = 1'b0;
          timeout_nx  = 1'b0;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // Strobes are registered, so they key off the state being entered.
    if (state_nx == S_CLR) begin
      wen_ext_2_nx   = 1'b1;
      addr_ext_2_nx  = MAILBOX_ADDR;
      wdata_ext_2_nx = '0;
      cycles_nx      = '0;
    end
    if (state_nx == S_RUN) begin
      ren_ext_2_nx  = 1'b1;
      addr_ext_2_nx = MAILBOX_ADDR;
    end
    if (cpu_enable) cycles_nx = cycles_run + 32'd1;

    cpu_enable_nx = (state_nx == S_RUN);
    done_nx       = (state_nx == S_DONE);
    busy_nx       = (state_nx == S_LOAD) || (state_nx == S_CLR) || (state_nx == S_RUN);
    load_ready_nx = (state_nx == S_IDLE) || (state_nx == S_LOAD);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state        <= S_IDLE;
      imem_ptr     <= '0;
      dmem_ptr     <= '0;
      poll_pending <= 1'b0;
      rd_issue     <= 1'b0;
      rd_ret       <= 1'b0;
      load_ready   <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      cpu_enable   <= 1'b0;
      addr_ext     <= '0;
      wen_ext      <= 1'b0;
      ren_ext      <= 1'b0;
      wdata_ext    <= '0;
      addr_ext_2   <= '0;
      wen_ext_2    <= 1'b0;
      ren_ext_2    <= 1'b0;
      wdata_ext_2  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      load_err     <= 1'b0;
      cycles_run   <= '0;
    end else begin
      state        <= state_nx;
      imem_ptr     <= imem_ptr_nx;
      dmem_ptr     <= dmem_ptr_nx;
      poll_pending <= poll_nx;
      rd_issue     <= rd_issue_nx;
      rd_ret       <= rd_ret_nx;
      load_ready   <= load_ready_nx;
      rd_valid     <= rd_valid_nx;
      rd_data      <= rd_data_nx;
      cpu_enable   <= cpu_enable_nx;
      addr_ext     <= addr_ext_nx;
      wen_ext      <= wen_ext_nx;
      ren_ext      <= 1'b0;
      wdata_ext    <= wdata_ext_nx;
      addr_ext_2   <= addr_ext_2_nx;
      wen_ext_2    <= wen_ext_2_nx;
      ren_ext_2    <= ren_ext_2_nx;
      wdata_ext_2  <= wdata_ext_2_nx;
      busy         <= busy_nx;
      done         <= done_nx;
      timeout      <= timeout_nx;
      load_err     <= load_err_nx;
      cycles_run   <= cycles_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// tb_cpu_run_ctrl: directed self-checking bench with a small dmem/mailbox model.
// Revision 1.0
module tb_cpu_run_ctrl;

  localparam logic [63:0] C_MAILBOX = 64'h1FF8;
  localparam logic [63:0] C_MAGIC   = 64'h00000000DEADBEEF;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        load_valid, load_ready, load_target, load_last;
  logic [63:0] load_data;
  logic        go, clear, rd_req, rd_valid;
  logic [31:0] cycle_limit;
  logic [63:0] rd_addr, rd_data;
  logic        cpu_enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
  logic [31:0] wdata_ext, rdata_ext, cycles_run;
  logic        busy, done, timeout, load_err;

  int checks   = 0;
  int failures = 0;

  logic [63:0] mem [0:1023];
  logic        halt_mode;
  int          en_cnt;

  cpu_run_ctrl dut (
    .clk(clk), .arst_n(arst_n),
    .load_valid(load_valid), .load_ready(load_ready), .load_target(load_target),
    .load_last(load_last), .load_data(load_data),
    .go(go), .cycle_limit(cycle_limit), .clear(clear),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .cpu_enable(cpu_enable),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .busy(busy), .done(done), .timeout(timeout), .load_err(load_err),
    .cycles_run(cycles_run)
  );

  always #5 clk = ~clk;

  // Dmem model with 1-cycle read latency; in halt_mode the program "writes"
  // HALT_MAGIC so that the poll issued in enabled cycle 19 returns it.
  always @(posedge clk) begin
    if (wen_ext_2) mem[addr_ext_2[12:3]] <= wdata_ext_2;
    if (ren_ext_2) begin
      if (halt_mode && (addr_ext_2 == C_MAILBOX) && (en_cnt >= 19)) rdata_ext_2 <= C_MAGIC;
      else rdata_ext_2 <= mem[addr_ext_2[12:3]];
    end
    if (wen_ext_2 && (addr_ext_2 == C_MAILBOX)) en_cnt <= 0;
    else if (cpu_enable) en_cnt <= en_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic load_beat(input logic tgt, input logic last, input logic [63:0] d);
    load_valid = 1'b1; load_target = tgt; load_last = last; load_data = d;
    @(posedge clk); #1;
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic run_until_done(output int en_seen);
    en_seen = 0;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (done) break;
      if (cpu_enable) en_seen++;
    end
  endtask

  int          n_en, n_wen, n_rd;
  logic [63:0] last_waddr;
  logic [63:0] rd_got [0:1];

  initial begin
    arst_n = 1'b0; load_valid = 1'b0; load_target = 1'b0; load_last = 1'b0;
    load_data = '0; go = 1'b0; cycle_limit = '0; clear = 1'b0; rd_req = 1'b0;
    rd_addr = '0; rdata_ext = '0; halt_mode = 1'b0; en_cnt = 0; rdata_ext_2 = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_enable", 64'(cpu_enable), 64'd0);
    check("rst_outs_zero", 64'(|{load_ready, rd_valid, rd_data, addr_ext, wen_ext, ren_ext,
          wdata_ext, addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2, busy, done, timeout,
          load_err, cycles_run}), 64'd0);
    @(negedge clk); arst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_load_ready", 64'(load_ready), 64'd1);

    for (int i = 0; i < 3; i++) begin
      load_beat(1'b0, i == 2, 64'hA0 + 64'(i));
      check("imem_wen", 64'(wen_ext), 64'd1);
      check("imem_addr", addr_ext, 64'(i * 4));
      check("imem_wdata", 64'(wdata_ext), 64'hA0 + 64'(i));
    end
    check("imem_idle_busy", 64'(busy), 64'd0);
    check("imem_ready_kept", 64'(load_ready), 64'd1);

    load_beat(1'b1, 1'b0, 64'h11);
    check("dmem0_addr", addr_ext_2, 64'd0);
    check("dmem0_data", wdata_ext_2, 64'h11);
    check("dmem_load_busy", 64'(busy), 64'd1);
    load_beat(1'b1, 1'b1, 64'h22);
    check("dmem1_addr", addr_ext_2, 64'd8);
    check("dmem1_data", wdata_ext_2, 64'h22);
    @(posedge clk); #1;
    check("wen2_idle_zero", 64'(wen_ext_2), 64'd0);
    load_beat(1'b1, 1'b1, 64'h33);
    check("dmem2_wen", 64'(wen_ext_2), 64'd1);
    check("dmem2_addr", addr_ext_2, 64'd16);
    check("dmem2_data", wdata_ext_2, 64'h33);
    @(posedge clk); #1;

    // Halting run: mailbox cleared in CLR, then 21 enabled cycles.
    halt_mode = 1'b1; cycle_limit = 32'd0;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    check("clr_wen2", 64'(wen_ext_2), 64'd1);
    check("clr_addr2", addr_ext_2, C_MAILBOX);
    check("clr_wdata2", wdata_ext_2, 64'd0);
    check("clr_cpu_enable", 64'(cpu_enable), 64'd0);
    @(posedge clk); #1;
    check("run_poll_ren", 64'(ren_ext_2), 64'd1);
    check("run_poll_addr", addr_ext_2, C_MAILBOX);
    n_en = 1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (done) break;
      if (cpu_enable) n_en++;
    end
    check("halt_done", 64'(done), 64'd1);
    check("halt_enabled_cycles", 64'(n_en), 64'd21);
    check("halt_cycles_run", 64'(cycles_run), 64'd21);
    check("halt_timeout", 64'(timeout), 64'd0);
    check("halt_cpu_enable_off", 64'(cpu_enable), 64'd0);
    check("done_load_ready", 64'(load_ready), 64'd0);
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    check("done_ignores_go", 64'(cpu_enable), 64'd0);
    pulse_clear();
    check("clr1_done", 64'(done), 64'd0);

    // Budgeted run: mailbox never matches.
    halt_mode = 1'b0; cycle_limit = 32'd10;
    run_until_done(n_en);
    check("to_done", 64'(done), 64'd1);
    check("to_enabled_cycles", 64'(n_en), 64'd10);
    check("to_cycles_run", 64'(cycles_run), 64'd10);
    check("to_timeout", 64'(timeout), 64'd1);

    // Back-to-back readback.
    rd_req = 1'b1; rd_addr = 64'd8;
    @(posedge clk); #1;
    check("rd_ren", 64'(ren_ext_2), 64'd1);
    check("rd_addr0", addr_ext_2, 64'd8);
    rd_addr = 64'd16;
    @(posedge clk); #1;
    check("rd_addr1", addr_ext_2, 64'd16);
    rd_req = 1'b0;
    n_rd = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rd_valid && n_rd < 2) begin
        rd_got[n_rd] = rd_data;
        n_rd++;
      end
    end
    check("rd_count", 64'(n_rd), 64'd2);
    check("rd_data0", rd_got[0], 64'h22);
    check("rd_data1", rd_got[1], 64'h33);
    pulse_clear();
    check("clr2_done", 64'(done), 64'd0);
    check("clr2_timeout", 64'(timeout), 64'd0);
    check("clr2_busy", 64'(busy), 64'd0);
    check("clr2_ready", 64'(load_ready), 64'd1);

    // Imem overflow after clear: pointer restarts at 0, beat 513 is dropped.
    n_wen = 0; last_waddr = '1;
    for (int i = 0; i < 513; i++) begin
      load_beat(1'b0, i == 512, 64'(i));
      if (i == 0) check("ovf_first_addr", addr_ext, 64'd0);
      if (i == 511) check("ovf_err_before", 64'(load_err), 64'd0);
      if (wen_ext) begin
        n_wen++;
        last_waddr = addr_ext;
      end
    end
    check("ovf_last_no_wen", 64'(wen_ext), 64'd0);
    check("ovf_load_err", 64'(load_err), 64'd1);
    check("ovf_wen_count", 64'(n_wen), 64'd512);
    check("ovf_last_addr", last_waddr, 64'd2044);
    pulse_clear();
    check("idle_clear_err", 64'(load_err), 64'd0);

    // Asynchronous reset in the middle of a run.
    cycle_limit = 32'd0;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_run_enable", 64'(cpu_enable), 64'd1);
    #2 arst_n = 1'b0;
    #1;
    check("arst_cpu_enable", 64'(cpu_enable), 64'd0);
    check("arst_outs_zero", 64'(|{load_ready, rd_valid, rd_data, addr_ext, wen_ext, ren_ext,
          wdata_ext, addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2, busy, done, timeout,
          load_err, cycles_run}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
